// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the memory-interface responder.
// Maps byte addresses to word indices and byte enables to bit masks.
package mem_if_pkg;

   localparam int unsigned MEM_DATA_WIDTH = 64;
   localparam int unsigned MEM_BE_WIDTH   = MEM_DATA_WIDTH / 8;
   localparam int unsigned MEM_ADDR_WIDTH = 64;
   localparam int unsigned MEM_IDX_MAX_W  = 32;

   typedef struct packed {
      logic                      valid;
      logic [MEM_DATA_WIDTH-1:0] data;
   } resp_t;

   // Word index = idx_w address bits starting at the byte-offset boundary.
   function automatic logic [MEM_IDX_MAX_W-1:0] addr_to_index(
      input logic [MEM_ADDR_WIDTH-1:0] addr,
      input int unsigned               offs,
      input int unsigned               idx_w
   );
      logic [MEM_ADDR_WIDTH-1:0] shifted;
      logic [MEM_ADDR_WIDTH-1:0] mask;
      shifted = addr >> offs;
      mask    = (MEM_ADDR_WIDTH'(1) << idx_w) - MEM_ADDR_WIDTH'(1);
      return MEM_IDX_MAX_W'(shifted & mask);
   endfunction

   function automatic logic [MEM_DATA_WIDTH-1:0] be_to_mask(
      input logic [MEM_BE_WIDTH-1:0] be
   );
      logic [MEM_DATA_WIDTH-1:0] mask;
      mask = '0;
      for (int unsigned i = 0; i < MEM_BE_WIDTH; i++) begin
         mask[i*8 +: 8] = {8{be[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/mem_if_resp_pipe.sv
// Fixed-depth valid/data shift register carrying responses from grant to output.
module mem_if_resp_pipe
   import mem_if_pkg::*;
#(
   parameter int unsigned STAGES = 1
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   input  resp_t in_i,
   output resp_t out_o
);

   resp_t stage_q [STAGES];
   resp_t stage_d [STAGES];

   always_comb begin
      stage_d[0] = in_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign out_o = stage_q[STAGES-1];

endmodule

// File: rtl/mem_if_responder.sv
// Slave-side memory responder: word array behind a programmable grant delay
// and a fixed-latency, in-order response pipeline.
module mem_if_responder
   import mem_if_pkg::*;
#(
   parameter int unsigned ADDRESS_SIZE = 64,
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned DEPTH        = 1024,
   parameter int unsigned GNT_DELAY    = 0,
   parameter int unsigned RD_LATENCY   = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [ADDRESS_SIZE-1:0]   address_i,
   input  logic [DATA_WIDTH-1:0]     data_wdata_i,
   input  logic                      data_req_i,
   input  logic                      data_we_i,
   input  logic [DATA_WIDTH/8-1:0]   data_be_i,
   output logic                      data_gnt_o,
   output logic                      data_rvalid_o,
   output logic [DATA_WIDTH-1:0]     data_rdata_o
);

   localparam int unsigned BE_W  = DATA_WIDTH / 8;
   localparam int unsigned OFFS  = $clog2(BE_W);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
      $error("DEPTH must be a power of two");
   end
   if ((DATA_WIDTH % 8) != 0) begin : g_chk_dw
      $error("DATA_WIDTH must be a multiple of 8");
   end
   if (DATA_WIDTH != MEM_DATA_WIDTH) begin : g_chk_pkg
      $error("DATA_WIDTH must match mem_if_pkg::MEM_DATA_WIDTH");
   end
   if ((RD_LATENCY < 1) || (RD_LATENCY > 8)) begin : g_chk_lat
      $error("RD_LATENCY must be in 1..8");
   end

   logic gnt_c;

   if (GNT_DELAY == 0) begin : g_no_delay
      assign gnt_c = data_req_i;
   end else begin : g_delay
      localparam int unsigned CNT_W = $clog2(GNT_DELAY + 1);
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GNT_DELAY);

      typedef enum logic {ST_IDLE, ST_WAIT} gnt_state_e;

      gnt_state_e       state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             gnt_fsm_c;

      // Each request must be held GNT_DELAY cycles; dropping it early restarts the count.
      always_comb begin
         state_d   = state_q;
         cnt_d     = cnt_q;
         gnt_fsm_c = 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (data_req_i) begin
                  if (cnt_q == CNT_MAX) begin
                     gnt_fsm_c = 1'b1;
                     cnt_d     = '0;
                  end else begin
                     cnt_d   = cnt_q + CNT_W'(1);
                     state_d = ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!data_req_i) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else if (cnt_q == CNT_MAX) begin
                  gnt_fsm_c = 1'b1;
                  cnt_d     = '0;
                  state_d   = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         endcase
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      assign gnt_c = gnt_fsm_c;
   end

   assign data_gnt_o = gnt_c;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [IDX_W-1:0]      idx_c;
   logic [DATA_WIDTH-1:0] rd_word_c;
   logic [DATA_WIDTH-1:0] mask_c;
   logic [DATA_WIDTH-1:0] wr_word_c;
   logic                  wr_en_c;
   resp_t                 push_c;
   resp_t                 pipe_out;

   // Reads sample the array at the grant edge, so later writes cannot reach in-flight data.
   always_comb begin
      idx_c       = IDX_W'(addr_to_index(MEM_ADDR_WIDTH'(address_i), OFFS, IDX_W));
      rd_word_c   = mem_q[idx_c];
      mask_c      = be_to_mask(data_be_i);
      wr_word_c   = (rd_word_c & ~mask_c) | (data_wdata_i & mask_c);
      wr_en_c     = gnt_c & data_we_i;
      push_c.valid = gnt_c;
      push_c.data  = (gnt_c && !data_we_i) ? MEM_DATA_WIDTH'(rd_word_c) : '0;
   end

   always_ff @(posedge clk_i) begin
      if (wr_en_c) begin
         mem_q[idx_c] <= wr_word_c;
      end
   end

   mem_if_resp_pipe #(
      .STAGES (RD_LATENCY)
   ) u_resp_pipe (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .in_i   (push_c),
      .out_o  (pipe_out)
   );

   assign data_rvalid_o = pipe_out.valid;
   assign data_rdata_o  = DATA_WIDTH'(pipe_out.data);

   property p_payload_stable;
      @(posedge clk_i) disable iff (!rst_ni)
         (data_req_i && !data_gnt_o) |=>
            (!data_req_i || ($stable(address_i) && $stable(data_we_i) &&
                             $stable(data_wdata_i) && $stable(data_be_i)));
   endproperty
   a_payload_stable: assert property (p_payload_stable)
      else $error("request payload changed while waiting for grant");

   a_req_known: assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(data_req_i))
      else $error("data_req_i is unknown");

endmodule
